// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control unit: state codes, opcodes, functs,
// ALU control codes and datapath mux select encodings.
package mc_ctrl_pkg;

  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_TRAP    = 4'd12,
    S_BNEEX   = 4'd13
  } state_e;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RT   = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUSRCB_B     = 2'b00;
  localparam logic [1:0] ALUSRCB_4     = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALURES = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

endpackage

// File: rtl/multicycle_controller_if.sv
// Instruction fields, status and datapath control signals between the controller and datapath.
interface multicycle_controller_if #(
  parameter int unsigned OP_W      = 6,
  parameter int unsigned FUNCT_W   = 6,
  parameter int unsigned ALUCTRL_W = 3
);
  logic [OP_W-1:0]      op;
  logic [FUNCT_W-1:0]   funct;
  logic                 zero;
  logic                 mem_ready;
  logic                 memwrite;
  logic                 irwrite;
  logic                 pcen;
  logic                 iord;
  logic                 regdst;
  logic                 memtoreg;
  logic                 regwrite;
  logic                 alusrca;
  logic [1:0]           alusrcb;
  logic [1:0]           pcsrc;
  logic [ALUCTRL_W-1:0] alucontrol;
  logic                 illegal_op;

  modport master (
    output op, funct, zero, mem_ready,
    input  memwrite, irwrite, pcen, iord, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, alucontrol, illegal_op
  );

  modport slave (
    input  op, funct, zero, mem_ready,
    output memwrite, irwrite, pcen, iord, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, alucontrol, illegal_op
  );
endinterface

// File: rtl/mc_aludec.sv
// ALU decoder: maps aluop (and funct for R-type) to the ALU control code and
// reports whether the funct is a supported one.
module mc_aludec
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned FUNCT_W   = 6,
  parameter int unsigned ALUCTRL_W = 3
) (
  input  logic [FUNCT_W-1:0]   i_funct,
  input  aluop_e               i_aluop,
  output logic [ALUCTRL_W-1:0] o_alucontrol_c,
  output logic                 o_funct_valid_c
);

  logic [2:0] w_code;

  always_comb begin
    w_code          = ALU_ADD;
    o_funct_valid_c = 1'b1;
    case (i_aluop)
      ALUOP_ADD: w_code = ALU_ADD;
      ALUOP_SUB: w_code = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct)
          FUNCT_W'(FUNCT_ADD): w_code = ALU_ADD;
          FUNCT_W'(FUNCT_SUB): w_code = ALU_SUB;
          FUNCT_W'(FUNCT_AND): w_code = ALU_AND;
          FUNCT_W'(FUNCT_OR):  w_code = ALU_OR;
          FUNCT_W'(FUNCT_SLT): w_code = ALU_SLT;
          default:             o_funct_valid_c = 1'b0;
        endcase
      end
      default: w_code = ALU_ADD;
    endcase
  end

  // Codes are 3 bits; wider control buses get zero-extended.
  assign o_alucontrol_c = ALUCTRL_W'(w_code);

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control unit: Moore FSM over fetch/decode/execute/memory/writeback with a
// memory-ready stall and a sticky illegal-instruction trap. Define MULTICYCLE_BNE_EN to add bne.
module multicycle_controller
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned OP_W      = 6,
  parameter int unsigned FUNCT_W   = 6,
  parameter int unsigned ALUCTRL_W = 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  multicycle_controller_if.slave   ctrl_bus
);

  state_e               r_state;
  state_e               w_next;
  logic                 r_illegal_op;
  logic                 w_memwrite;
  logic                 w_irwrite;
  logic                 w_pcen;
  logic                 w_regwrite;
  logic                 w_iord;
  logic                 w_regdst;
  logic                 w_memtoreg;
  logic                 w_alusrca;
  logic [1:0]           w_alusrcb;
  logic [1:0]           w_pcsrc;
  aluop_e               w_aluop;
  logic [ALUCTRL_W-1:0] w_alucontrol;
  logic                 w_funct_valid;

  mc_aludec #(
    .FUNCT_W   (FUNCT_W),
    .ALUCTRL_W (ALUCTRL_W)
  ) u_aludec (
    .i_funct         (ctrl_bus.funct),
    .i_aluop         (w_aluop),
    .o_alucontrol_c  (w_alucontrol),
    .o_funct_valid_c (w_funct_valid)
  );

  // The trap flag is set on entry so it is already high in the first TRAP cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_FETCH;
      r_illegal_op <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_illegal_op <= r_illegal_op | (w_next == S_TRAP);
    end
  end

  always_comb begin
    w_next     = S_FETCH;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_pcen     = 1'b0;
    w_regwrite = 1'b0;
    w_iord     = 1'b0;
    w_regdst   = 1'b0;
    w_memtoreg = 1'b0;
    w_alusrca  = 1'b0;
    w_alusrcb  = ALUSRCB_4;
    w_pcsrc    = PCSRC_ALURES;
    w_aluop    = ALUOP_ADD;
    case (r_state)
      S_FETCH: begin
        w_irwrite = ctrl_bus.mem_ready;
        w_pcen    = ctrl_bus.mem_ready;
        w_next    = ctrl_bus.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        w_alusrcb = ALUSRCB_IMMSH;
        if (ctrl_bus.op == OP_W'(OP_LW) || ctrl_bus.op == OP_W'(OP_SW)) w_next = S_MEMADR;
        else if (ctrl_bus.op == OP_W'(OP_RT))   w_next = S_RTYPEEX;
        else if (ctrl_bus.op == OP_W'(OP_BEQ))  w_next = S_BEQEX;
        else if (ctrl_bus.op == OP_W'(OP_ADDI)) w_next = S_ADDIEX;
        else if (ctrl_bus.op == OP_W'(OP_J))    w_next = S_JEX;
`ifdef MULTICYCLE_BNE_EN
        else if (ctrl_bus.op == OP_W'(OP_BNE))  w_next = S_BNEEX;
`else
        else if (ctrl_bus.op == OP_W'(OP_BNE))  w_next = S_TRAP;
`endif
        else                                    w_next = S_TRAP;
      end
      S_MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = ALUSRCB_IMM;
        w_next    = (ctrl_bus.op == OP_W'(OP_SW)) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_iord = 1'b1;
        w_next = ctrl_bus.mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        w_memtoreg = 1'b1;
        w_regwrite = 1'b1;
      end
      S_MEMWR: begin
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
        w_next     = ctrl_bus.mem_ready ? S_FETCH : S_MEMWR;
      end
      S_RTYPEEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = ALUSRCB_B;
        w_aluop   = ALUOP_FUNCT;
        w_next    = w_funct_valid ? S_RTYPEWB : S_TRAP;
      end
      S_RTYPEWB: begin
        w_regdst   = 1'b1;
        w_regwrite = 1'b1;
      end
      S_BEQEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = ALUSRCB_B;
        w_aluop   = ALUOP_SUB;
        w_pcsrc   = PCSRC_ALUOUT;
        w_pcen    = ctrl_bus.zero;
      end
`ifdef MULTICYCLE_BNE_EN
      S_BNEEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = ALUSRCB_B;
        w_aluop   = ALUOP_SUB;
        w_pcsrc   = PCSRC_ALUOUT;
        w_pcen    = ~ctrl_bus.zero;
      end
`endif
      S_ADDIEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = ALUSRCB_IMM;
        w_next    = S_ADDIWB;
      end
      S_ADDIWB: w_regwrite = 1'b1;
      S_JEX: begin
        w_pcsrc = PCSRC_JUMP;
        w_pcen  = 1'b1;
      end
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_FETCH;
    endcase
  end

  // Write enables are held off for as long as reset is asserted.
  assign ctrl_bus.memwrite   = w_memwrite & reset_n;
  assign ctrl_bus.irwrite    = w_irwrite  & reset_n;
  assign ctrl_bus.pcen       = w_pcen     & reset_n;
  assign ctrl_bus.regwrite   = w_regwrite & reset_n;
  assign ctrl_bus.iord       = w_iord;
  assign ctrl_bus.regdst     = w_regdst;
  assign ctrl_bus.memtoreg   = w_memtoreg;
  assign ctrl_bus.alusrca    = w_alusrca;
  assign ctrl_bus.alusrcb    = w_alusrcb;
  assign ctrl_bus.pcsrc      = w_pcsrc;
  assign ctrl_bus.alucontrol = w_alucontrol;
  assign ctrl_bus.illegal_op = r_illegal_op;

endmodule
